integral_scan_controller: RTL

INTEGRAL_SCAN_CONTROLLER -- requirements
Module: integral_scan_controller

---
 rtl/integral_scan_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/integral_scan_controller.sv
// Integral-image scan controller: flushes the line-buffer memory, streams
// camera pixels into it, and hands each complete integral window to the
// classifier, waiting for its acknowledge before accepting more pixels.
module integral_scan_controller #(
    parameter int DATA_WIDTH_12       = 12,
    parameter int INTEGRAL_WIDTH      = 3,
    parameter int INTEGRAL_HEIGHT     = 3,
    parameter int FRAME_CAMERA_WIDTH  = 10,
    parameter int FRAME_CAMERA_HEIGHT = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic [DATA_WIDTH_12-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     mem_reset,
    output logic                     mem_wen,
    output logic [DATA_WIDTH_12-1:0] mem_pixel,
    output logic                     win_valid,
    output logic [DATA_WIDTH_12-1:0] win_x,
    output logic [DATA_WIDTH_12-1:0] win_y,
    input  logic                     win_ack,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int DW = DATA_WIDTH_12;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_SETTLE   = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [DW-1:0] X_LAST = DW'(FRAME_CAMERA_WIDTH - 1);
    localparam logic [DW-1:0] Y_LAST = DW'(FRAME_CAMERA_HEIGHT - 1);
    localparam logic [DW-1:0] X_MIN  = DW'(INTEGRAL_WIDTH - 1);
    localparam logic [DW-1:0] Y_MIN  = DW'(INTEGRAL_HEIGHT - 1);
    localparam logic [DW-1:0] ONE    = DW'(1);
    localparam logic [DW-1:0] ZERO   = DW'(0);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nx;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic          r_last_corner;
    logic          r_mem_wen;
    logic [DW-1:0] r_mem_pixel;
    logic          r_win_valid;
    logic [DW-1:0] r_win_x;
    logic [DW-1:0] r_win_y;
    logic          w_accept;
    logic          w_corner;
    logic          w_last;

    assign w_accept = pix_valid && (r_state == S_STREAM);
    assign w_corner = (r_x >= X_MIN) && (r_y >= Y_MIN);
    assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);

    // Next-state selection for the frame sequencer.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_FLUSH;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_FLUSH:  w_state_nx = S_STREAM;
            S_STREAM: begin
                if (w_accept && w_corner) begin
                    w_state_nx = S_SETTLE;
                end else begin
                    w_state_nx = S_STREAM;
                end
            end
            S_SETTLE: w_state_nx = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (win_ack) begin
                    w_state_nx = r_last_corner ? S_DONE : S_STREAM;
                end else begin
                    w_state_nx = S_WAIT_ACK;
                end
            end
            S_DONE:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Pixel coordinate counters: raster order, y saturates on the last row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= ZERO;
            r_y <= ZERO;
        end else if (r_state == S_FLUSH) begin
            r_x <= ZERO;
            r_y <= ZERO;
        end else if (w_accept) begin
            if (r_x == X_LAST) begin
                r_x <= ZERO;
                r_y <= (r_y == Y_LAST) ? r_y : (r_y + ONE);
            end else begin
                r_x <= r_x + ONE;
                r_y <= r_y;
            end
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

    // Memory write port: accepted pixel appears one cycle after the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_wen   <= 1'b0;
            r_mem_pixel <= ZERO;
        end else begin
            r_mem_wen   <= w_accept;
            r_mem_pixel <= w_accept ? pix_data : r_mem_pixel;
        end
    end

    // Window coordinates latched from the corner pixel; held through WAIT_ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_x       <= ZERO;
            r_win_y       <= ZERO;
            r_last_corner <= 1'b0;
        end else if (w_accept && w_corner) begin
            r_win_x       <= r_x - X_MIN;
            r_win_y       <= r_y - Y_MIN;
            r_last_corner <= w_last;
        end else begin
            r_win_x       <= r_win_x;
            r_win_y       <= r_win_y;
            r_last_corner <= r_last_corner;
        end
    end

    // Window-valid flag mirrors residence in WAIT_ACK as a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= (w_state_nx == S_WAIT_ACK);
        end
    end

    assign pix_ready  = (r_state == S_STREAM);
    assign mem_reset  = (r_state == S_FLUSH);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);
    assign mem_wen    = r_mem_wen;
    assign mem_pixel  = r_mem_pixel;
    assign win_valid  = r_win_valid;
    assign win_x      = r_win_x;
    assign win_y      = r_win_y;

endmodule
